srio_treq_dispatch: RTL

Packet-level router between the SRIO core's target request stream (treq) and the receive engines. Decodes the HELLO header on the first beat of each packet and steers the whole packet to the doorbell engine or the NWRITE/SWRITE engine, holding the route until `tlast`. Unsupported packets are consumed and counted. Replaces the OR-ed `tready` fan-out in `srio_rxc`, so exactly one engine sees each packet.

---
 rtl/srio_treq_dispatch_if.sv | 12 +
 rtl/srio_treq_dispatch.sv | 97 +++++++++
 2 files changed

// File: rtl/srio_treq_dispatch_if.sv
// AXI-Stream bundle used for the SRIO treq input and both engine outputs.
interface srio_treq_dispatch_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [31:0] tuser;

    modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
    modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/srio_treq_dispatch.sv
// Packet router: treq stream -> doorbell engine, NWRITE/SWRITE engine, or drop.
// Optional destination-ID filter compiled in with SRIO_TREQ_DESTCHK_EN.
module srio_treq_dispatch #(
    parameter logic [15:0] C_DEV_ID = 16'hF201,
    parameter int          C_CNT_W  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    srio_treq_dispatch_if.slave   s_axis_treq,
    srio_treq_dispatch_if.master  m_axis_db,
    srio_treq_dispatch_if.master  m_axis_nw,
    output logic [C_CNT_W-1:0]    drop_count,
    output logic                  drop_pulse
);

`ifdef SRIO_TREQ_DESTCHK_EN
    localparam bit DESTCHK = 1'b1;
`else
    localparam bit DESTCHK = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_DB, ST_NW, ST_DROP} state_t;

    state_t               state_reg, state_next;
    state_t               route_dec, route;
    logic [C_CNT_W-1:0]   drop_count_reg;
    logic                 drop_pulse_reg;
    logic                 in_ready, accept, drop_accept;
    logic [3:0]           ftype, ttype;

    assign ftype = s_axis_treq.tdata[55:52];
    assign ttype = s_axis_treq.tdata[51:48];

    always_comb begin
        route_dec = ST_DROP;
        if (ftype == 4'hA)
            route_dec = ST_DB;
        else if (ftype == 4'h6 || (ftype == 4'h5 && (ttype == 4'h4 || ttype == 4'h5)))
            route_dec = ST_NW;
        if (DESTCHK && s_axis_treq.tuser[15:0] != C_DEV_ID)
            route_dec = ST_DROP;
    end

    // Header is decoded only in IDLE; mid-packet the stored route wins.
    assign route = (state_reg == ST_IDLE) ? route_dec : state_reg;

    always_comb begin
        in_ready = 1'b0;
        if (!areset) begin
            case (route)
                ST_DB:   in_ready = m_axis_db.tready;
                ST_NW:   in_ready = m_axis_nw.tready;
                ST_DROP: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign s_axis_treq.tready = in_ready;
    assign accept      = s_axis_treq.tvalid && in_ready;
    assign drop_accept = accept && s_axis_treq.tlast && (route == ST_DROP);

    assign m_axis_db.tvalid = !areset && s_axis_treq.tvalid && (route == ST_DB);
    assign m_axis_nw.tvalid = !areset && s_axis_treq.tvalid && (route == ST_NW);

    assign m_axis_db.tdata = s_axis_treq.tdata;
    assign m_axis_db.tkeep = s_axis_treq.tkeep;
    assign m_axis_db.tlast = s_axis_treq.tlast;
    assign m_axis_db.tuser = s_axis_treq.tuser;
    assign m_axis_nw.tdata = s_axis_treq.tdata;
    assign m_axis_nw.tkeep = s_axis_treq.tkeep;
    assign m_axis_nw.tlast = s_axis_treq.tlast;
    assign m_axis_nw.tuser = s_axis_treq.tuser;

    always_comb begin
        state_next = state_reg;
        if (accept)
            state_next = s_axis_treq.tlast ? ST_IDLE : route;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg      <= ST_IDLE;
            drop_count_reg <= '0;
            drop_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            drop_pulse_reg <= drop_accept;
            if (drop_accept && drop_count_reg != {C_CNT_W{1'b1}})
                drop_count_reg <= drop_count_reg + {{(C_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign drop_count = drop_count_reg;
    assign drop_pulse = drop_pulse_reg;

endmodule
